// File: rtl/float_pkg.sv
// Shared single-precision field widths, constants, FSM state type and unpack helpers
// for the calculator float units.
package float_pkg;

   localparam int EXP_W   = 8;
   localparam int MAN_W   = 23;
   localparam int BIAS    = 127;
   localparam int EXP_MAX = 2 * BIAS + 1;

   localparam logic [31:0] QNAN    = 32'h7FC00000;
   localparam logic [31:0] POS_INF = 32'h7F800000;
   localparam logic [31:0] NEG_INF = 32'hFF800000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ALIGN = 3'd1,
      ST_SUB   = 3'd2,
      ST_NORM  = 3'd3,
      ST_ROUND = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   function automatic logic f_sign(input logic [31:0] f);
      return f[31];
   endfunction

   function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] f);
      return f[30:23];
   endfunction

   function automatic logic [MAN_W-1:0] f_man(input logic [31:0] f);
      return f[22:0];
   endfunction

endpackage

// File: rtl/float_align_shift.sv
// Combinational right barrel shifter for mantissa alignment; bits shifted out are
// collapsed into a single sticky flag.
module float_align_shift #(
   parameter int W = 27
) (
   input  logic [W-1:0] man_i,
   input  logic [7:0]   shamt_i,
   output logic [W-1:0] man_o,
   output logic         sticky_o
);

   logic [W-1:0] mask_s;

   always_comb begin
      man_o    = '0;
      sticky_o = 1'b0;
      mask_s   = '0;
      if (shamt_i > 8'(W - 1)) begin
         man_o    = '0;
         sticky_o = |man_i;
      end else begin
         mask_s   = ~({W{1'b1}} << shamt_i);
         man_o    = man_i >> shamt_i;
         sticky_o = |(man_i & mask_s);
      end
   end

endmodule

// File: rtl/float_sub.sv
// Multi-cycle IEEE-754 single subtractor S = A - B with start/done handshake.
// Define FLOAT_SUB_ADD_MODE_EN to add the op port (op=1 selects A + B).
module float_sub
   import float_pkg::*;
#(
   parameter int GRS_BITS = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
`ifdef FLOAT_SUB_ADD_MODE_EN
   input  logic        op,
`endif
   output logic        busy,
   output logic        done,
   output logic [31:0] S,
   output logic        overflow
);

   localparam int MW = MAN_W + 1 + GRS_BITS;

   state_e        state_q, state_d;
   logic [31:0]   a_q, a_d, b_q, b_d, s_q, s_d;
   logic          flip_q, flip_d, eff_sub_q, eff_sub_d, sign_q, sign_d, ovf_q, ovf_d;
   logic [9:0]    exp_q, exp_d;
   logic [MW-1:0] big_q, big_d, small_q, small_d;
   logic [MW:0]   man_q, man_d;
   logic          busy_q, done_q;

   logic          flip_s;
   logic [7:0]    ea_s, eb_s, diff_s;
   logic [MW-1:0] ma_s, mb_s, sh_in_s, sh_out_s;
   logic          sa_s, sb_s, sticky_s, a_ge_b_s;
   logic          a_nan_s, b_nan_s, a_inf_s, b_inf_s;
   logic          round_up_s;
   logic [24:0]   rnd_s;
   logic [9:0]    rexp_s;
   logic [22:0]   rfrac_s;

`ifdef FLOAT_SUB_ADD_MODE_EN
   assign flip_s = ~op;
`else
   assign flip_s = 1'b1;
`endif

   // Denormal operands collapse to zero: exponent 0 and an empty mantissa.
   assign ea_s     = f_exp(a_q);
   assign eb_s     = f_exp(b_q);
   assign ma_s     = (ea_s == 8'h00) ? '0 : {1'b1, f_man(a_q), {GRS_BITS{1'b0}}};
   assign mb_s     = (eb_s == 8'h00) ? '0 : {1'b1, f_man(b_q), {GRS_BITS{1'b0}}};
   assign sa_s     = f_sign(a_q);
   assign sb_s     = f_sign(b_q) ^ flip_q;
   assign a_nan_s  = (ea_s == 8'hFF) && (f_man(a_q) != 23'h0);
   assign b_nan_s  = (eb_s == 8'hFF) && (f_man(b_q) != 23'h0);
   assign a_inf_s  = (ea_s == 8'hFF) && (f_man(a_q) == 23'h0);
   assign b_inf_s  = (eb_s == 8'hFF) && (f_man(b_q) == 23'h0);
   assign a_ge_b_s = {ea_s, ma_s} >= {eb_s, mb_s};
   assign diff_s   = a_ge_b_s ? (ea_s - eb_s) : (eb_s - ea_s);
   assign sh_in_s  = a_ge_b_s ? mb_s : ma_s;

   float_align_shift #(.W(MW)) u_align (
      .man_i   (sh_in_s),
      .shamt_i (diff_s),
      .man_o   (sh_out_s),
      .sticky_o(sticky_s)
   );

   // Round-to-nearest-even on the guard/round/sticky bits below the 24-bit mantissa.
   assign round_up_s = man_q[GRS_BITS-1] & (man_q[GRS_BITS-2] | man_q[GRS_BITS-3] | man_q[GRS_BITS]);
   assign rnd_s      = {1'b0, man_q[MW-1:GRS_BITS]} + 25'(round_up_s);
   assign rexp_s     = exp_q + {9'h000, rnd_s[24]};
   assign rfrac_s    = rnd_s[24] ? rnd_s[23:1] : rnd_s[22:0];

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      flip_d    = flip_q;
      eff_sub_d = eff_sub_q;
      sign_d    = sign_q;
      exp_d     = exp_q;
      big_d     = big_q;
      small_d   = small_q;
      man_d     = man_q;
      s_d       = s_q;
      ovf_d     = ovf_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               flip_d  = flip_s;
               state_d = ST_ALIGN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ALIGN: begin
            if (a_nan_s || b_nan_s || (a_inf_s && b_inf_s && (sa_s != sb_s))) begin
               s_d     = QNAN;
               ovf_d   = 1'b0;
               state_d = ST_DONE;
            end else if (a_inf_s) begin
               s_d     = sa_s ? NEG_INF : POS_INF;
               ovf_d   = 1'b0;
               state_d = ST_DONE;
            end else if (b_inf_s) begin
               s_d     = sb_s ? NEG_INF : POS_INF;
               ovf_d   = 1'b0;
               state_d = ST_DONE;
            end else begin
               sign_d    = a_ge_b_s ? sa_s : sb_s;
               exp_d     = {2'b00, (a_ge_b_s ? ea_s : eb_s)};
               eff_sub_d = (sa_s != sb_s);
               big_d     = a_ge_b_s ? ma_s : mb_s;
               small_d   = sh_out_s | {{(MW-1){1'b0}}, sticky_s};
               state_d   = ST_SUB;
            end
         end
         ST_SUB: begin
            if (eff_sub_q) begin
               man_d = {1'b0, big_q} - {1'b0, small_q};
            end else begin
               man_d = {1'b0, big_q} + {1'b0, small_q};
            end
            state_d = ST_NORM;
         end
         ST_NORM: begin
            if (man_q[MW]) begin
               man_d   = {1'b0, man_q[MW:2], man_q[1] | man_q[0]};
               exp_d   = exp_q + 10'd1;
               state_d = ST_ROUND;
            end else if (man_q == '0) begin
               s_d     = 32'h00000000;
               ovf_d   = 1'b0;
               state_d = ST_DONE;
            end else if (man_q[MW-1]) begin
               state_d = ST_ROUND;
            end else if (exp_q <= 10'd1) begin
               // The next left shift would reach exponent 0: flush to +0.
               s_d     = 32'h00000000;
               ovf_d   = 1'b0;
               state_d = ST_DONE;
            end else begin
               man_d = {man_q[MW-1:0], 1'b0};
               exp_d = exp_q - 10'd1;
            end
         end
         ST_ROUND: begin
            if (rexp_s >= 10'(EXP_MAX)) begin
               s_d   = {sign_q, 8'hFF, 23'h000000};
               ovf_d = 1'b1;
            end else begin
               s_d   = {sign_q, rexp_s[7:0], rfrac_s};
               ovf_d = 1'b0;
            end
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         a_q       <= 32'h0;
         b_q       <= 32'h0;
         flip_q    <= 1'b0;
         eff_sub_q <= 1'b0;
         sign_q    <= 1'b0;
         exp_q     <= 10'h0;
         big_q     <= '0;
         small_q   <= '0;
         man_q     <= '0;
         s_q       <= 32'h0;
         ovf_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         flip_q    <= flip_d;
         eff_sub_q <= eff_sub_d;
         sign_q    <= sign_d;
         exp_q     <= exp_d;
         big_q     <= big_d;
         small_q   <= small_d;
         man_q     <= man_d;
         s_q       <= s_d;
         ovf_q     <= ovf_d;
         busy_q    <= (state_d == ST_ALIGN) || (state_d == ST_SUB) ||
                      (state_d == ST_NORM)  || (state_d == ST_ROUND);
         done_q    <= (state_d == ST_DONE);
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign S        = s_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_float_sub.sv
// Scoreboard bench for float_sub: directed vectors push expected results, a negedge
// monitor pops and compares on every done pulse.
module tb_float_sub;

   logic        clk = 1'b0;
   logic        rst, start, busy, done, overflow;
   logic [31:0] A, B, S;
`ifdef FLOAT_SUB_ADD_MODE_EN
   logic        op;
`endif

   always #5 clk = ~clk;

   float_sub dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .A       (A),
      .B       (B),
`ifdef FLOAT_SUB_ADD_MODE_EN
      .op      (op),
`endif
      .busy    (busy),
      .done    (done),
      .S       (S),
      .overflow(overflow)
   );

   typedef struct {
      logic [31:0] s;
      logic        ovf;
      int          lat;
      int          t0;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;
   int   n_vec = 0;
   int   n_miss = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_done: got S=%h with no request outstanding", S);
         end else begin
            e = sb_q.pop_front();
            chk("S", S, e.s);
            chk("overflow", {31'h0, overflow}, {31'h0, e.ovf});
            if (e.lat >= 0) chk("latency", cyc - e.t0, e.lat);
         end
      end
   end

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                         input logic ovf, input int lat, input bit mid);
      exp_t x;
      bit   seen;
      @(negedge clk);
      A = a;
      B = b;
      start = 1'b1;
      x.s = s; x.ovf = ovf; x.lat = lat; x.t0 = cyc + 1;
      sb_q.push_back(x);
      seen = 1'b0;
      for (int i = 0; i < 64 && !seen; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (mid && i == 0) begin
            start = 1'b1;
            A = 32'h7FC00000;
            B = 32'h3F800000;
         end
         if (done === 1'b1) begin
            seen = 1'b1;
            chk("busy_at_done", {31'h0, busy}, 32'h0);
         end else begin
            chk("busy_running", {31'h0, busy}, 32'h1);
         end
      end
      start = 1'b0;
      if (!seen) begin
         n_vec++;
         n_miss++;
         $display("FAIL done_timeout: got no done in 64 cycles, expected done for A=%h B=%h", a, b);
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      A = 32'h0;
      B = 32'h0;
`ifdef FLOAT_SUB_ADD_MODE_EN
      op = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_S", S, 32'h0);
      chk("rst_ovf", {31'h0, overflow}, 32'h0);
      rst = 1'b0;

      run_op(32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 4, 1'b0);  // 3 - 1
      run_op(32'h3F800000, 32'hBF800000, 32'h40000000, 1'b0, 4, 1'b0);  // 1 - (-1), carry
      run_op(32'h3F800000, 32'h3F7FFFFF, 32'h33800000, 1'b0, 28, 1'b0); // 24 left shifts
      run_op(32'h42F60000, 32'h42F60000, 32'h00000000, 1'b0, -1, 1'b0); // exact zero
      run_op(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 4, 1'b0);  // overflow
      run_op(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1'b0, 1, 1'b0);  // NaN operand
      run_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1, 1'b0);  // inf - inf
      run_op(32'h7F800000, 32'hFF800000, 32'h7F800000, 1'b0, 1, 1'b0);  // inf - (-inf)
      run_op(32'h3F800000, 32'h7F800000, 32'hFF800000, 1'b0, 1, 1'b0);  // 1 - inf
      run_op(32'h00400000, 32'h3F800000, 32'hBF800000, 1'b0, 4, 1'b0);  // denormal - 1
      run_op(32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 1'b0, 5, 1'b0);  // 1 - 2^-24
      run_op(32'h3F800000, 32'hB3800000, 32'h3F800000, 1'b0, 4, 1'b0);  // tie to even, down
      run_op(32'h3F800001, 32'hB3800000, 32'h3F800002, 1'b0, 4, 1'b0);  // tie to even, up
      run_op(32'h3FFFFFFF, 32'hB3800000, 32'h40000000, 1'b0, 4, 1'b0);  // round carry
      run_op(32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 4, 1'b1);  // start while busy

      // Reset in the middle of NORM aborts without a done pulse.
      @(negedge clk);
      A = 32'h3F800000;
      B = 32'h3F7FFFFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'h0, busy}, 32'h0);
      chk("abort_done", {31'h0, done}, 32'h0);
      chk("abort_S", S, 32'h0);
      chk("abort_ovf", {31'h0, overflow}, 32'h0);
      run_op(32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 4, 1'b0);

      repeat (6) @(negedge clk);
      chk("scoreboard_empty", sb_q.size(), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
